// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: ALU codes, FSM states,
// opcode/funct values, operand/PC select codes and the decoded instruction class.
package mc_ctrl_pkg;

  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_ZIMM = 2'd2;
  localparam logic [1:0] SRCB_SIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_IMM,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_BAD
  } iclass_e;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Instruction decoder: maps opcode/funct to an instruction class and the ALU
// operation used in EXEC. Anything not recognised is CL_BAD (retired as a nop).
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic [3:0] alu_op
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    iclass = CL_BAD;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin iclass = CL_RTYPE; alu_op = ALU_ADD; end
          FN_SUB: begin iclass = CL_RTYPE; alu_op = ALU_SUB; end
          FN_OR:  begin iclass = CL_RTYPE; alu_op = ALU_OR;  end
          FN_XOR: begin iclass = CL_RTYPE; alu_op = ALU_XOR; end
          FN_SLL: begin iclass = CL_RTYPE; alu_op = ALU_SLL; end
          default: ;
        endcase
      end
      OP_ORI:  begin iclass = CL_IMM; alu_op = ALU_OR;  end
      OP_LUI:  begin iclass = CL_IMM; alu_op = ALU_LUI; end
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      OP_BEQ:  begin iclass = CL_BEQ; alu_op = ALU_SUB; end
      OP_J:    iclass = CL_J;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM with
// combinational control decode and a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memAck,
  output logic        memReq,
  output logic        memWe,
  output logic        iorD,
  output logic        irWr,
  output logic        pcWr,
  output logic        regWr,
  output logic [3:0]  aluOp,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic        regDst,
  output logic        memToReg,
  output logic [1:0]  pcSrc,
  output logic [2:0]  state,
  output logic [31:0] retireCnt
);

  state_e     state_q;
  state_e     state_d;
  iclass_e    iclass;
  logic [3:0] dec_alu_op;
  logic       retire;

  mc_ctrl_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

  always_comb begin
    state_d  = state_q;
    memReq   = 1'b0;
    memWe    = 1'b0;
    iorD     = 1'b0;
    irWr     = 1'b0;
    pcWr     = 1'b0;
    regWr    = 1'b0;
    aluOp    = ALU_ADD;
    aluSrcA  = 1'b0;
    aluSrcB  = SRCB_RT;
    regDst   = 1'b0;
    memToReg = 1'b0;
    pcSrc    = PCSRC_ALU;
    // Reset holds every control at its idle value; the register forces FETCH.
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          memReq  = 1'b1;
          aluSrcB = SRCB_FOUR;
          if (memAck) begin
            irWr    = 1'b1;
            pcWr    = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (iclass)
            CL_J:    state_d = ST_WB;
            CL_BAD:  state_d = ST_FETCH;
            default: state_d = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          aluOp = dec_alu_op;
          case (iclass)
            CL_RTYPE: begin
              aluSrcA = 1'b1;
              state_d = ST_WB;
            end
            CL_IMM: begin
              aluSrcB = SRCB_ZIMM;
              state_d = ST_WB;
            end
            CL_LW, CL_SW: begin
              aluSrcB = SRCB_SIMM;
              state_d = ST_MEM;
            end
            CL_BEQ: begin
              pcWr    = zero;
              pcSrc   = PCSRC_BR;
              state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          memReq = 1'b1;
          iorD   = 1'b1;
          memWe  = (iclass == CL_SW);
          if (memAck) state_d = (iclass == CL_LW) ? ST_WB : ST_FETCH;
        end
        ST_WB: begin
          case (iclass)
            CL_RTYPE: begin regWr = 1'b1; regDst = 1'b1; end
            CL_IMM:   regWr = 1'b1;
            CL_LW:    begin regWr = 1'b1; memToReg = 1'b1; end
            CL_J:     begin pcWr = 1'b1; pcSrc = PCSRC_JMP; end
            default: ;
          endcase
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // An instruction retires on the cycle it hands control back to FETCH.
  assign retire = (state_q != ST_FETCH) && (state_d == ST_FETCH);
  assign state  = state_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (reset) begin
      state_q   <= ST_FETCH;
      retireCnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retireCnt <= retireCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction phase model builds the
// expected control vector of every cycle; a compare process checks the DUT.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk, reset, zero, memAck;
  logic [5:0]  opcode, funct;
  logic        memReq, memWe, iorD, irWr, pcWr, regWr, aluSrcA, regDst, memToReg;
  logic [3:0]  aluOp;
  logic [1:0]  aluSrcB, pcSrc;
  logic [2:0]  st;
  logic [31:0] retireCnt;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .memAck(memAck), .memReq(memReq), .memWe(memWe), .iorD(iorD), .irWr(irWr),
    .pcWr(pcWr), .regWr(regWr), .aluOp(aluOp), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .regDst(regDst), .memToReg(memToReg), .pcSrc(pcSrc),
    .state(st), .retireCnt(retireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        rst;
    bit [5:0]  op;
    bit [5:0]  fn;
    bit        z;
    bit        ack;
    bit [2:0]  st;
    bit        mreq, mwe, iord, irw, pcw, rgw;
    bit [3:0]  aop;
    bit        asa;
    bit [1:0]  asb;
    bit        rd, m2r;
    bit [1:0]  pcs;
    bit [31:0] rc;
  } cyc_t;

  localparam int K_R = 0, K_ORI = 1, K_LUI = 2, K_LW = 3, K_SW = 4,
                 K_BEQ = 5, K_J = 6, K_BAD = 7;

  cyc_t        exp_q[$];
  logic [31:0] cnt_m;
  bit          ack_hold;
  int          checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int kind_of(input bit [5:0] op, input bit [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100101 ||
                         fn == 6'b100110 || fn == 6'b000000) ? K_R : K_BAD;
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_BAD;
    endcase
  endfunction

  function automatic bit [3:0] r_alu(input bit [5:0] fn);
    case (fn)
      6'b100010: return ALU_SUB;
      6'b100101: return ALU_OR;
      6'b100110: return ALU_XOR;
      6'b000000: return ALU_SLL;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic cyc_t base(input bit [2:0] s);
    cyc_t r;
    r     = '0;
    r.st  = s;
    r.aop = ALU_ADD;
    r.rc  = cnt_m;
    r.op  = 6'($urandom);
    r.fn  = 6'($urandom);
    r.z   = 1'($urandom);
    r.ack = ack_hold ? 1'b1 : 1'($urandom);
    return r;
  endfunction

  task automatic cyc(input cyc_t r);
    @(posedge clk);
    #1;
    reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z; memAck = r.ack;
    exp_q.push_back(r);
  endtask

  task automatic reset_cycles(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r     = base(ST_FETCH);
      r.rst = 1'b1;
      cyc(r);
      cnt_m = '0;
    end
  endtask

  // Idle FETCH cycle with no expectation queued; used for literal probes.
  task automatic gap();
    @(posedge clk);
    #1;
    reset = 1'b0; memAck = 1'b0;
  endtask

  task automatic run_instr(input bit [5:0] op, input bit [5:0] fn, input int fwait,
                           input int mwait, input bit zb, input int rst_mem);
    cyc_t r;
    int   k;
    k = kind_of(op, fn);
    for (int i = 0; i <= fwait; i++) begin
      r      = base(ST_FETCH);
      r.ack  = (i == fwait);
      r.mreq = 1'b1;
      r.asb  = 2'd1;
      r.irw  = r.ack;
      r.pcw  = r.ack;
      cyc(r);
    end
    r = base(ST_DECODE); r.op = op; r.fn = fn;
    cyc(r);
    if (k == K_BAD) begin cnt_m++; return; end
    if (k != K_J) begin
      r = base(ST_EXEC); r.op = op; r.fn = fn;
      case (k)
        K_R:        begin r.asa = 1'b1; r.aop = r_alu(fn); end
        K_ORI:      begin r.asb = 2'd2; r.aop = ALU_OR; end
        K_LUI:      begin r.asb = 2'd2; r.aop = ALU_LUI; end
        K_LW, K_SW: r.asb = 2'd3;
        K_BEQ:      begin r.aop = ALU_SUB; r.z = zb; r.pcw = zb; r.pcs = 2'd1; end
        default: ;
      endcase
      cyc(r);
      if (k == K_BEQ) begin cnt_m++; return; end
    end
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mwait; i++) begin
        r = base(ST_MEM); r.op = op; r.fn = fn;
        if (i == rst_mem) begin
          r.rst = 1'b1;
          r.ack = 1'b1;
          cyc(r);
          cnt_m = '0;
          return;
        end
        r.ack  = (i == mwait);
        r.mreq = 1'b1;
        r.iord = 1'b1;
        r.mwe  = (k == K_SW);
        cyc(r);
      end
      if (k == K_SW) begin cnt_m++; return; end
    end
    r = base(ST_WB); r.op = op; r.fn = fn;
    case (k)
      K_R:          begin r.rgw = 1'b1; r.rd = 1'b1; end
      K_ORI, K_LUI: r.rgw = 1'b1;
      K_LW:         begin r.rgw = 1'b1; r.m2r = 1'b1; end
      K_J:          begin r.pcw = 1'b1; r.pcs = 2'd2; end
      default: ;
    endcase
    cyc(r);
    cnt_m++;
  endtask

  // Compare process: every queued cycle is checked at the falling edge.
  initial begin
    cyc_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("state",     st,        r.st);
        check("memReq",    memReq,    r.mreq);
        check("memWe",     memWe,     r.mwe);
        check("iorD",      iorD,      r.iord);
        check("irWr",      irWr,      r.irw);
        check("pcWr",      pcWr,      r.pcw);
        check("regWr",     regWr,     r.rgw);
        check("aluOp",     aluOp,     r.aop);
        check("aluSrcA",   aluSrcA,   r.asa);
        check("aluSrcB",   aluSrcB,   r.asb);
        check("regDst",    regDst,    r.rd);
        check("memToReg",  memToReg,  r.m2r);
        check("pcSrc",     pcSrc,     r.pcs);
        check("retireCnt", retireCnt, r.rc);
      end
    end
  end

  initial begin
    bit [5:0] ops[7];
    bit [5:0] fns[5];
    bit [5:0] op, fn;
    ops = '{OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
    fns = '{FN_ADD, FN_SUB, FN_OR, FN_XOR, FN_SLL};
    checks = 0; errors = 0; cnt_m = '0; ack_hold = 1'b0;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; memAck = 1'b1;
    @(posedge clk);
    reset_cycles(2);
    @(negedge clk);
    check("rst_state", st, 3'd0);
    check("rst_retire", retireCnt, 32'd0);
    check("rst_memReq", memReq, 1'b0);

    ack_hold = 1'b1;
    run_instr(OP_RTYPE, FN_ADD, 0, 0, 1'b0, -1);
    ack_hold = 1'b0;
    gap();
    @(negedge clk);
    check("add_retire", retireCnt, 32'd1);
    check("add_state", st, 3'd0);

    run_instr(6'b111111, 6'($urandom), 0, 0, 1'b0, -1);
    gap();
    @(negedge clk);
    check("bad_retire", retireCnt, 32'd2);

    run_instr(OP_BEQ, 6'($urandom), 0, 0, 1'b1, -1);
    run_instr(OP_BEQ, 6'($urandom), 0, 0, 1'b0, -1);
    run_instr(OP_LW, 6'($urandom), 1, 3, 1'b0, -1);
    gap();
    @(negedge clk);
    check("lw_retire", retireCnt, 32'd5);

    run_instr(OP_SW, 6'($urandom), 0, 3, 1'b0, 1);
    reset_cycles(1);
    @(negedge clk);
    check("swrst_state", st, 3'd0);
    check("swrst_memReq", memReq, 1'b0);
    check("swrst_memWe", memWe, 1'b0);
    check("swrst_retire", retireCnt, 32'd0);

    gap();
    force dut.retireCnt = 32'hFFFF_FFFF;
    #1;
    release dut.retireCnt;
    @(negedge clk);
    check("preload", retireCnt, 32'hFFFF_FFFF);
    cnt_m = 32'hFFFF_FFFF;
    run_instr(OP_J, 6'($urandom), 0, 0, 1'b0, -1);
    gap();
    @(negedge clk);
    check("j_wrap", retireCnt, 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(24, 0) == 0) reset_cycles(int'($urandom_range(2, 1)));
      case ($urandom_range(9, 0))
        0, 1: begin op = OP_RTYPE; fn = fns[$urandom_range(4, 0)]; end
        2:    begin op = OP_RTYPE; fn = 6'($urandom); end
        3:    begin op = 6'($urandom); fn = 6'($urandom); end
        default: begin op = ops[$urandom_range(6, 1)]; fn = 6'($urandom); end
      endcase
      run_instr(op, fn, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                1'($urandom), -1);
    end

    gap();
    @(negedge clk);
    if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  6  IR[31:26]; valid from DECODE onward.
REQ-004 funct  input  6  IR[5:0]; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 memAck  input  1  memory completes the current request this cycle.
REQ-007 memReq  output  1  memory request pending.
REQ-008 memWe  output  1  request is a write.
REQ-009 iorD  output  1  memory address: 0 = PC, 1 = ALUOut.
REQ-010 irWr, pcWr, regWr  output  1 each  IR, PC and register-file write enables.
REQ-011 aluOp  output  4  ALU operation; uses the existing ALU_* encodings.
REQ-012 aluSrcA  output  1  0 = PC, 1 = rs.
REQ-013 aluSrcB  output  2  0 = rt, 1 = constant 4, 2 = zero-extended imm16, 3 = sign-extended imm16.
REQ-014 regDst  output  1  0 = rt, 1 = rd.
REQ-015 memToReg  output  1  0 = ALUOut, 1 = MDR.
REQ-016 pcSrc  output  2  0 = ALU result, 1 = branch target, 2 = jump target.
REQ-017 state  output  3  current state, for debug.
REQ-018 retireCnt  output  32  count of retired instructions.

Function
REQ-019 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB; outputs SHALL be Moore-decoded from the state and the current opcode/funct.
REQ-020 FETCH: memReq=1, memWe=0, iorD=0, aluSrcA=0, aluSrcB=1, aluOp=ADD; on memAck assert irWr=1, pcWr=1, pcSrc=0, then go to DECODE; without memAck stay in FETCH with no write enables.
REQ-021 DECODE: no write enables; j goes to WB, supported instructions go to EXEC, unsupported opcode/funct goes to FETCH and retires as a nop.
REQ-022 EXEC R-type (funct add 100000, sub 100010, or 100101, xor 100110, sll 000000): aluSrcA=1, aluSrcB=0, aluOp by funct, next state WB.
REQ-023 EXEC ori/lui (001101/001111): aluSrcB=2, aluOp OR or LUI, next state WB.
REQ-024 EXEC lw/sw (100011/101011): aluSrcB=3, aluOp=ADD, next state MEM.
REQ-025 EXEC beq (000100): aluOp=SUB, aluSrcB=0; pcWr=zero, pcSrc=1; next state FETCH.
REQ-026 MEM: memReq=1, iorD=1, memWe=1 for sw; hold until memAck; on ack lw goes to WB and sw goes to FETCH.
REQ-027 WB: R-type sets regWr=1, regDst=1, memToReg=0; ori/lui sets regWr=1, regDst=0; lw sets regWr=1, regDst=0, memToReg=1; j sets pcWr=1, pcSrc=2; next state FETCH.
REQ-028 With zero-wait memory, latency SHALL be: R/ori/lui 4 cycles, lw 5, sw 4, beq 3, j 3, unsupported 2.
REQ-029 retireCnt SHALL increment by 1 (wrapping modulo 2^32) on the cycle an instruction leaves its last state to enter FETCH.
REQ-030 memAck while memReq=0 SHALL be ignored.
REQ-031 memWe SHALL never be 1 unless memReq=1; regWr, pcWr and irWr SHALL be one-cycle pulses per instruction.

Reset
REQ-032 reset=1 at an edge SHALL force state=FETCH and retireCnt=0, regardless of current state or any pending memAck.
REQ-033 While reset=1, all enables and memReq SHALL be 0; aluOp=ADD and all selects 0.
REQ-034 Reset in MEM during a pending sw SHALL drop memReq/memWe on the next cycle with no register write and no retire.

Structure
REQ-035 State encodings (ST_FETCH..ST_WB), opcode/funct constants and aluSrcB/pcSrc codes SHALL be added to the shared macro header, next to the ALU_* codes.
REQ-036 Next-state logic and output decode SHALL be combinational; only state and retireCnt SHALL be registered.
REQ-037 One sub-module, mc_ctrl_dec, SHALL map opcode/funct to the instruction class and aluOp.

Verification
REQ-038 add, memAck held 1 -> states F,D,E,W,F; regWr=1 with regDst=1 only in WB; retireCnt 0->1.
REQ-039 lw with memAck low for 3 cycles in MEM -> memReq=1, iorD=1 held 4 cycles; regWr with memToReg=1 one cycle after ack.
REQ-040 beq with zero=1, then with zero=0 -> pcWr=1 and pcSrc=1 in EXEC for the first; pcWr=0 for the second; each 3 cycles.
REQ-041 opcode 111111 -> DECODE to FETCH, no writes, retireCnt +1.
REQ-042 sw, reset asserted in MEM before ack -> next cycle state=FETCH, memReq=0, memWe=0, retireCnt=0.
REQ-043 j with retireCnt preloaded via 0xFFFFFFFF retires -> WB pcWr=1 with pcSrc=2; retireCnt wraps to 0.
